// File: rtl/mem_io_bridge.sv
// mem_io_bridge: memory-side stage behind the 16-bit multicycle datapath.
// Routes load/store requests to an external synchronous block RAM or to a
// small I/O page (switches, LED register, transmit FIFO). A req/ready
// handshake lets the datapath stall on RAM reads and on pushes to a full FIFO.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for MemRead/MemWrite; request latched on leaving
// ACCESS | RAM address/write strobe presented, or I/O read/write performed;
//        | held here while a FIFO push waits for room
// RDWAIT | RAM read data arrives; captured into MemOut
// RESP   | MemReady pulse; requests are not sampled
module mem_io_bridge #(
    parameter int RAM_AW     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [15:0]       Addr,
    input  logic [15:0]       WriteData,
    output logic [15:0]       MemOut,
    output logic              MemReady,
    output logic [RAM_AW-1:0] RamAddr,
    output logic              RamWE,
    output logic [15:0]       RamDin,
    input  logic [15:0]       RamDout,
    input  logic [15:0]       Switches,
    output logic [15:0]       LedOut,
    output logic [15:0]       TxData,
    output logic              TxValid,
    input  logic              TxAck,
    output logic [CNT_W-1:0]  TxCount
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             op_wr;
    logic [15:0]      addr_q;
    logic [15:0]      sw_meta;
    logic [15:0]      sw_sync;
    logic [15:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             is_io;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push_req;
    logic             push;
    logic [15:0]      io_rdata;

    assign is_io      = (addr_q[15:8] == 8'hFF);
    assign fifo_full  = (TxCount == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (TxCount == '0);
    assign pop        = TxAck && !fifo_empty;
    assign push_req   = (state == ACCESS) && op_wr && (addr_q == 16'hFF02);
    // a push into a full FIFO still goes through if the head leaves this cycle
    assign push       = push_req && (!fifo_full || pop);
    assign TxData     = fifo_mem[rd_ptr];
    assign TxValid    = !fifo_empty;

    // state register
    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state decode plus the single-cycle strobes
    always_comb begin
        state_nxt = state;
        MemReady  = 1'b0;
        RamWE     = 1'b0;
        case (state)
            IDLE: begin
                if (MemRead || MemWrite) state_nxt = ACCESS;
            end
            ACCESS: begin
                if (!is_io) begin
                    RamWE     = op_wr;
                    state_nxt = op_wr ? RESP : RDWAIT;
                end else if (push_req && !push) begin
                    state_nxt = ACCESS;
                end else begin
                    state_nxt = RESP;
                end
            end
            RDWAIT: state_nxt = RESP;
            RESP: begin
                MemReady  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // an access interrupted by reset must not complete or write
        if (Reset) begin
            MemReady = 1'b0;
            RamWE    = 1'b0;
        end
    end

    // request latch; RamDin doubles as the latched store data for I/O writes
    always_ff @(posedge CLK) begin
        if (Reset) begin
            op_wr   <= 1'b0;
            addr_q  <= '0;
            RamAddr <= '0;
            RamDin  <= '0;
        end else if ((state == IDLE) && (MemRead || MemWrite)) begin
            op_wr   <= MemWrite;
            addr_q  <= Addr;
            RamAddr <= Addr[RAM_AW-1:0];
            RamDin  <= WriteData;
        end
    end

    // I/O page read mux
    always_comb begin
        io_rdata = '0;
        case (addr_q)
            16'hFF00: io_rdata = sw_sync;
            16'hFF01: io_rdata = LedOut;
            16'hFF02: io_rdata = {14'b0, fifo_full, fifo_empty};
            16'hFF03: io_rdata = {{(16-CNT_W){1'b0}}, TxCount};
            default:  io_rdata = '0;
        endcase
    end

    // load data capture and LED register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            MemOut <= '0;
            LedOut <= '0;
        end else begin
            if ((state == ACCESS) && is_io && !op_wr) MemOut <= io_rdata;
            if (state == RDWAIT)                      MemOut <= RamDout;
            if ((state == ACCESS) && op_wr && (addr_q == 16'hFF01)) LedOut <= RamDin;
        end
    end

    // two-flop switch synchronizer, free running
    always_ff @(posedge CLK) begin
        if (Reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= Switches;
            sw_sync <= sw_meta;
        end
    end

    // FIFO storage, no reset needed since TxValid masks stale entries
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= RamDin;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            TxCount <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   TxCount <= TxCount + CNT_W'(1);
                2'b01:   TxCount <= TxCount - CNT_W'(1);
                default: TxCount <= TxCount;
            endcase
        end
    end

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
Memory-side stage directly downstream of the 16-bit multicycle datapath. It accepts the datapath's load/store requests and routes them either to an external synchronous block RAM or to a small memory-mapped I/O page. The I/O page holds a switch input register, an LED output register and a transmit FIFO. A req/ready handshake lets the control FSM stall on slow accesses: RAM reads and transmit writes to a full FIFO.

Parameters:
RAM_AW, 10, RAM word-address width; RamAddr = latched Addr[RAM_AW-1:0]
FIFO_DEPTH, 4, TX FIFO entries (power of two, 2..8)
CNT_W, 4, width of TxCount; must hold FIFO_DEPTH

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  synchronous active-high reset
MemRead  in  1  load request; held until MemReady
MemWrite  in  1  store request; held until MemReady
Addr  in  16  word address
WriteData  in  16  store data
MemOut  out  16  load data, valid while MemReady=1, held afterwards
MemReady  out  1  one-cycle completion pulse
RamAddr  out  RAM_AW  BRAM address
RamWE  out  1  BRAM write enable
RamDin  out  16  BRAM write data
RamDout  in  16  BRAM read data, valid the cycle after RamAddr is presented
Switches  in  16  asynchronous board switches
LedOut  out  16  LED register
TxData  out  16  FIFO head
TxValid  out  1  FIFO not empty
TxAck  in  1  consumer pops head when TxValid&TxAck
TxCount  out  CNT_W  FIFO occupancy

Behaviour:
- Clock and reset: single clock CLK. Reset is synchronous and active-high.
- Reset effect: FSM returns to IDLE, any in-flight access is abandoned with no MemReady, and the FIFO empties.
- Values held in reset: MemOut=0, MemReady=0, RamWE=0, RamAddr=0, RamDin=0, LedOut=0, TxValid=0, TxCount=0, switch synchronizer=0.
- Address map:
  - Addr[15:8]!=8'hFF selects RAM.
  - 16'hFF00 (read only) returns the switches after a 2-flop synchronizer.
  - 16'hFF01 reads/writes LedOut.
  - 16'hFF02: a write pushes WriteData into the FIFO; a read returns {14'b0, full, empty}.
  - 16'hFF03 (read) returns zero-extended TxCount.
  - Any other FFxx address reads 0; writes are ignored.
- Simultaneous requests: MemRead and MemWrite high together are treated as a write, and MemOut is unchanged.
- FSM states IDLE, ACCESS, RDWAIT, RESP:
  - IDLE: if MemRead|MemWrite, latch Addr, WriteData and op, then go to ACCESS.
  - ACCESS, RAM region: drive RamAddr; RamWE=1 for exactly this cycle on a write. Read goes to RDWAIT; write goes to RESP.
  - ACCESS, I/O region: perform the I/O write or capture the I/O read data into MemOut at the closing edge, then go to RESP.
  - ACCESS, FIFO push while full with no same-cycle pop: remain in ACCESS (stall) until the push is accepted.
  - RDWAIT: capture RamDout into MemOut, then go to RESP.
  - RESP: MemReady=1 for this one cycle, then go to IDLE. Requests are not sampled during RESP.
- Latency, counted from the edge that samples the request in IDLE:
  - RAM read: MemReady high in cycle 3.
  - RAM write and all non-stalled I/O accesses: MemReady high in cycle 2.
- RamWE is never high outside ACCESS. RamAddr and RamDin hold their last values when idle.
- FIFO is circular with wrapping read/write pointers.
  - TxData = head, combinational from storage.
  - A pop and a push in the same cycle leave TxCount unchanged.
  - A push when full is accepted only if a pop occurs in the same cycle.
  - A pop when empty is ignored.
- Switch synchronizer runs continuously, independent of the FSM.

Test Plan:
- Reset, then MemWrite Addr=16'h0005 WriteData=16'hBEEF -> RamWE=1 for one cycle with RamAddr=5 and RamDin=BEEF; MemReady pulses 2 cycles after the request is sampled.
- MemRead Addr=16'h0005 with the BRAM model returning BEEF one cycle late -> MemOut=BEEF, MemReady pulses 3 cycles after the request; MemOut still BEEF after MemReady drops.
- Write 16'hFF01=16'h00A5, then read FF01 -> LedOut=00A5, MemOut=00A5. Switches=16'h1234 held 3 cycles, then read FF00 -> MemOut=1234. Read FF80 -> MemOut=0.
- With TxAck=0, push 1,2,3,4 to FF02 -> TxCount=4, FF02 read = 16'h0002. A 5th push stalls with MemReady=0. Raise TxAck for one cycle -> head 1 pops, the 5th push is accepted in the same cycle, TxCount stays 4, and MemReady pulses.
- Drain the FIFO with TxAck held high -> TxData sequence 2,3,4,5, then TxValid=0, TxCount=0, FF02 read = 16'h0001. Further TxAck has no effect.
- Assert Reset during RDWAIT of a RAM read, and separately during a stalled FIFO push -> no MemReady; all outputs zero next cycle; FIFO empty; next request serviced normally.
